// File: rtl/psram_qpi_responder.sv
// psram_qpi_responder: SPI/QPI PSRAM device model with a byte array, wait-state reads and a backdoor read port
module psram_qpi_responder #(
  parameter int WAIT_CYCLES = 6,
  parameter int ADDR_BITS = 8
) (
  input  logic                 mem_clk,
  input  logic                 rst,
  input  logic                 mem_ce,
  input  logic [3:0]           mem_sio_in,
  output logic [3:0]           mem_sio_out,
  output logic                 mem_sio_oe,
  output logic                 qpi_mode,
  output logic                 busy,
  output logic [15:0]          bytes_written,
  input  logic [ADDR_BITS-1:0] bd_addr,
  output logic [7:0]           bd_data
);
  localparam int CW = $clog2(WAIT_CYCLES + 8);
  typedef enum logic [2:0] {IDLE, SPI_CMD, QPI_CMD, ADDR, WR_DATA, RD_WAIT, RD_DATA, IGNORE} state_t;
  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d, cmd_full, rd_byte, bd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, addr_nx, rd_a;
  logic [3:0] hi_q, hi_d, out_q, out_d;
  logic ph_q, ph_d, qpi_q, qpi_d, arm_q, arm_d, oe_q, oe_d;
  logic cmd_done, addr_done, wait_done, is_rd, we;
  logic [15:0] bw_q, bw_d;
  logic [7:0] mem [2**ADDR_BITS];
  assign cmd_full = state_q == SPI_CMD ? {cmd_q[6:0], mem_sio_in[0]} : {cmd_q[3:0], mem_sio_in};
  assign cmd_done = state_q == QPI_CMD || (state_q == SPI_CMD && cnt_q == CW'(7));
  assign addr_nx = ADDR_BITS'({addr_q, mem_sio_in});
  assign addr_done = state_q == ADDR && cnt_q == CW'(5);
  assign is_rd = cmd_q == 8'hEB;
  // the clock that ends the wait window launches the first high nibble
  assign wait_done = WAIT_CYCLES == 0 ? addr_done && is_rd : state_q == RD_WAIT && cnt_q == CW'(WAIT_CYCLES - 1);
  assign rd_a = state_q == ADDR ? addr_nx : addr_q;
  assign rd_byte = mem[rd_a];
  assign we = !rst && !mem_ce && state_q == WR_DATA && ph_q;
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      hi_q <= '0;
      ph_q <= 1'b0;
      qpi_q <= 1'b0;
      arm_q <= 1'b0;
      oe_q <= 1'b0;
      out_q <= '0;
      bw_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      hi_q <= hi_d;
      ph_q <= ph_d;
      qpi_q <= qpi_d;
      arm_q <= arm_d;
      oe_q <= oe_d;
      out_q <= out_d;
      bw_q <= bw_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (mem_ce) state_d = IDLE;
    else
      case (state_q)
        IDLE: state_d = qpi_q ? QPI_CMD : SPI_CMD;
        SPI_CMD, QPI_CMD: if (cmd_done) state_d = qpi_q && (cmd_full == 8'h38 || cmd_full == 8'hEB) ? ADDR : IGNORE;
        ADDR: if (addr_done) state_d = !is_rd ? WR_DATA : WAIT_CYCLES == 0 ? RD_DATA : RD_WAIT;
        RD_WAIT: if (wait_done) state_d = RD_DATA;
        default: state_d = state_q;
      endcase
  end
  always_comb begin
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    hi_d = hi_q;
    ph_d = ph_q;
    qpi_d = qpi_q;
    arm_d = arm_q;
    oe_d = 1'b0;
    out_d = out_q;
    bw_d = bw_q;
    if (!mem_ce) begin
      case (state_q)
        IDLE: begin
          cmd_d = qpi_q ? {4'h0, mem_sio_in} : {7'h0, mem_sio_in[0]};
          cnt_d = CW'(1);
        end
        SPI_CMD, QPI_CMD: begin
          cmd_d = cmd_full;
          cnt_d = cmd_done ? '0 : cnt_q + 1'b1;
          if (cmd_done) begin
            arm_d = cmd_full == 8'h66;
            qpi_d = cmd_full == 8'h99 && arm_q ? 1'b0 : cmd_full == 8'h35 ? 1'b1 : qpi_q;
          end
        end
        ADDR: begin
          addr_d = addr_nx;
          cnt_d = addr_done ? '0 : cnt_q + 1'b1;
          ph_d = 1'b0;
        end
        WR_DATA: begin
          ph_d = ~ph_q;
          hi_d = ph_q ? hi_q : mem_sio_in;
          addr_d = ph_q ? addr_q + 1'b1 : addr_q;
          bw_d = ph_q && !(&bw_q) ? bw_q + 16'd1 : bw_q;
        end
        RD_WAIT: cnt_d = cnt_q + 1'b1;
        RD_DATA: begin
          oe_d = 1'b1;
          out_d = ph_q ? rd_byte[3:0] : rd_byte[7:4];
          ph_d = ~ph_q;
          addr_d = ph_q ? addr_q + 1'b1 : addr_q;
        end
        default: ;
      endcase
      if (wait_done) begin
        oe_d = 1'b1;
        out_d = rd_byte[7:4];
        ph_d = 1'b1;
      end
    end
  end
  // array has no reset; backdoor read sees the pre-write byte on a same-clock collision
  always_ff @(posedge mem_clk) begin
    if (we) mem[addr_q] <= {hi_q, mem_sio_in};
    bd_q <= rst ? 8'h00 : mem[bd_addr];
  end
  assign mem_sio_out = out_q;
  assign mem_sio_oe = oe_q;
  assign qpi_mode = qpi_q;
  assign busy = state_q != IDLE;
  assign bytes_written = bw_q;
  assign bd_data = bd_q;
endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb_psram_qpi_responder: vector table, directed corner sequences and random transactions against a transaction-level model
module tb_psram_qpi_responder;
  localparam int W = 6;
  logic mem_clk = 1'b0, rst = 1'b1, mem_ce = 1'b1;
  logic [3:0] sio = 4'h0, out;
  logic oe, qpi, busy;
  logic [15:0] bw;
  logic [7:0] bd_addr = 8'h00, bd_data;
  logic [7:0] ref_mem [256];
  logic [15:0] bw_ref = 16'h0;
  logic qpi_ref = 1'b0, arm_ref = 1'b0;
  logic [7:0] wq [$];
  int total = 0, bad = 0;
  typedef struct { logic [23:0] a; int n; logic [23:0] d; logic [7:0] ea; logic [7:0] ev; } vec_t;
  vec_t vt [4];

  psram_qpi_responder #(.WAIT_CYCLES(W), .ADDR_BITS(8)) dut (
    .mem_clk(mem_clk), .rst(rst), .mem_ce(mem_ce), .mem_sio_in(sio), .mem_sio_out(out),
    .mem_sio_oe(oe), .qpi_mode(qpi), .busy(busy), .bytes_written(bw), .bd_addr(bd_addr), .bd_data(bd_data)
  );

  always #5 mem_clk = ~mem_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick(input logic ce, input logic [3:0] n);
    mem_ce = ce;
    sio = n;
    @(posedge mem_clk);
    @(negedge mem_clk);
  endtask

  task automatic model_cmd(input logic [7:0] c);
    if (c == 8'h66) arm_ref = 1'b1;
    else begin
      if (c == 8'h99 && arm_ref) qpi_ref = 1'b0;
      else if (c == 8'h35) qpi_ref = 1'b1;
      arm_ref = 1'b0;
    end
  endtask

  task automatic bump_bw();
    bw_ref = bw_ref == 16'hFFFF ? bw_ref : bw_ref + 16'd1;
  endtask

  task automatic spi_cmd(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) begin
      tick(1'b0, {3'b0, c[i]});
      if (i == 7) check("spi_busy", 32'(busy), 32'd1);
    end
    tick(1'b1, 4'h0);
    model_cmd(c);
    check("spi_release_busy", 32'(busy), 32'd0);
    check("spi_qpi_mode", 32'(qpi), 32'(qpi_ref));
  endtask

  task automatic qpi_cmd(input logic [7:0] c);
    tick(1'b0, c[7:4]);
    tick(1'b0, c[3:0]);
    model_cmd(c);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) begin
      tick(1'b0, a[i*4 +: 4]);
      check("addr_oe", 32'(oe), 32'd0);
    end
  endtask

  task automatic write_txn(input logic [23:0] a);
    logic [7:0] p;
    qpi_cmd(8'h38);
    send_addr(a);
    foreach (wq[j]) begin
      tick(1'b0, wq[j][7:4]);
      tick(1'b0, wq[j][3:0]);
      check("wr_oe", 32'(oe), 32'd0);
    end
    tick(1'b1, 4'h0);
    p = a[7:0];
    foreach (wq[j]) begin
      ref_mem[p] = wq[j];
      p++;
      bump_bw();
    end
    check("wr_bytes_written", 32'(bw), 32'(bw_ref));
  endtask

  task automatic read_txn(input logic [23:0] a, input int nb);
    logic [7:0] b;
    qpi_cmd(8'hEB);
    send_addr(a);
    for (int w = 0; w < W - 1; w++) begin
      tick(1'b0, 4'h0);
      check("rd_wait_oe", 32'(oe), 32'd0);
    end
    for (int i = 0; i < 2 * nb; i++) begin
      tick(1'b0, 4'h0);
      b = ref_mem[a[7:0] + 8'(i / 2)];
      check("rd_oe", 32'(oe), 32'd1);
      check("rd_nibble", 32'(out), 32'(i % 2 == 1 ? b[3:0] : b[7:4]));
    end
    tick(1'b1, 4'h0);
    check("rd_end_oe", 32'(oe), 32'd0);
    check("rd_end_busy", 32'(busy), 32'd0);
  endtask

  task automatic bd_check(input string nm, input logic [7:0] a, input logic [7:0] exp);
    bd_addr = a;
    tick(1'b1, 4'h0);
    check(nm, 32'(bd_data), 32'(exp));
  endtask

  initial begin
    logic [7:0] old, old21, c;
    logic [3:0] n3;
    logic [23:0] ra;
    int op, n;
    vt[0] = '{24'h000010, 2, 24'hABCD00, 8'h10, 8'hAB};
    vt[1] = '{24'h0000FE, 3, 24'h112233, 8'h00, 8'h33};
    vt[2] = '{24'hFFFF40, 1, 24'h770000, 8'h40, 8'h77};
    vt[3] = '{24'h000050, 3, 24'h010203, 8'h51, 8'h02};
    tick(1'b1, 4'h0);
    tick(1'b1, 4'h0);
    check("rst_qpi", 32'(qpi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_oe", 32'(oe), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_bw", 32'(bw), 32'd0);
    check("rst_bd", 32'(bd_data), 32'd0);
    rst = 1'b0;
    spi_cmd(8'h66);
    spi_cmd(8'h99);
    spi_cmd(8'h35);
    check("init_qpi", 32'(qpi), 32'd1);
    for (int k = 0; k < 4; k++) begin
      wq.delete();
      for (int j = 0; j < vt[k].n; j++) wq.push_back(vt[k].d[23 - 8 * j -: 8]);
      write_txn(vt[k].a);
      bd_check("vec_expected", vt[k].ea, vt[k].ev);
      for (int j = 0; j < vt[k].n; j++) bd_check("vec_model", vt[k].a[7:0] + 8'(j), ref_mem[vt[k].a[7:0] + 8'(j)]);
      if (k == 0) check("vec0_bw_two", 32'(bw), 32'd2);
    end
    bd_check("wrap_fe", 8'hFE, 8'h11);
    bd_check("wrap_ff", 8'hFF, 8'h22);
    read_txn(24'h000010, 2);
    wq.delete();
    for (int j = 0; j < 256; j++) wq.push_back(8'($urandom));
    write_txn(24'h000000);
    qpi_cmd(8'h38);
    send_addr(24'h000020);
    old = ref_mem[8'h20];
    old21 = ref_mem[8'h21];
    bd_addr = 8'h20;
    tick(1'b0, ~old[7:4]);
    tick(1'b0, ~old[3:0]);
    check("bd_collision_old", 32'(bd_data), 32'(old));
    n3 = 4'($urandom);
    tick(1'b0, n3);
    tick(1'b1, 4'h0);
    check("abort_busy", 32'(busy), 32'd0);
    ref_mem[8'h20] = ~old;
    bump_bw();
    bd_check("abort_mem20", 8'h20, ~old);
    bd_check("abort_mem21", 8'h21, old21);
    check("abort_bw", 32'(bw), 32'(bw_ref));
    qpi_cmd(8'h66);
    tick(1'b1, 4'h0);
    qpi_cmd(8'h99);
    tick(1'b1, 4'h0);
    check("mode_reset_qpi", 32'(qpi), 32'd0);
    spi_cmd(8'h35);
    qpi_cmd(8'hEB);
    send_addr(24'h000010);
    for (int w = 0; w < W + 2; w++) tick(1'b0, 4'h0);
    check("pre_rst_oe", 32'(oe), 32'd1);
    rst = 1'b1;
    tick(1'b0, 4'h0);
    check("rst_mid_oe", 32'(oe), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_qpi", 32'(qpi), 32'd0);
    check("rst_mid_bw", 32'(bw), 32'd0);
    rst = 1'b0;
    qpi_ref = 1'b0;
    arm_ref = 1'b0;
    bw_ref = 16'h0;
    bd_check("rst_keeps_mem", 8'h10, ref_mem[8'h10]);
    spi_cmd(8'h35);
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 3));
      ra = 24'($urandom);
      if (op <= 1) begin
        wq.delete();
        n = int'($urandom_range(1, 8));
        for (int j = 0; j < n; j++) wq.push_back(8'($urandom));
        write_txn(ra);
        n = int'($urandom_range(0, wq.size() - 1));
        bd_check("rnd_wr_bd", ra[7:0] + 8'(n), ref_mem[ra[7:0] + 8'(n)]);
      end else if (op == 2) begin
        read_txn(ra, int'($urandom_range(1, 4)));
      end else begin
        do c = 8'($urandom); while (c == 8'h38 || c == 8'hEB || c == 8'h66 || c == 8'h99);
        qpi_cmd(c);
        for (int j = 0; j < 3; j++) begin
          tick(1'b0, 4'($urandom));
          check("ign_busy", 32'(busy), 32'd1);
          check("ign_oe", 32'(oe), 32'd0);
        end
        tick(1'b1, 4'h0);
        check("ign_qpi", 32'(qpi), 32'(qpi_ref));
        check("ign_bw", 32'(bw), 32'(bw_ref));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
